// File: rtl/ustream_bi_to_bin_pkg.sv
// rtl/ustream_bi_to_bin_pkg.sv - shared types and defaults for the bipolar stream-to-binary converter
package ustream_pkg;

  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/ustream_bi_to_bin_if.sv
// rtl/ustream_bi_to_bin_if.sv - sampling and result handshake bundle between producer, converter and consumer
interface ustream_bi_to_bin_if
  import ustream_pkg::*;
#(
  parameter int W = DEF_W
);

  logic         iStart;
  logic         iEn;
  logic         iBit;
  logic         iReady;
  logic         oBusy;
  logic         oValid;
  logic [W-1:0] oData;
  logic         oSat;

  modport master (
    output iStart, iEn, iBit, iReady,
    input  oBusy, oValid, oData, oSat
  );

  modport slave (
    input  iStart, iEn, iBit, iReady,
    output oBusy, oValid, oData, oSat
  );

endinterface

// File: rtl/ustream_bi_to_bin_win_cnt.sv
// rtl/ustream_bi_to_bin_win_cnt.sv - enable-gated W+1 bit window counter with sync clear and terminal flag
module uWinCnt
  import ustream_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [W:0] cnt_o,
  output logic       term_o
);

  localparam logic [W:0] TERM = {1'b1, {W{1'b0}}};

  logic [W:0] cnt_q;
  logic [W:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/ustream_bi_to_bin.sv
// rtl/ustream_bi_to_bin.sv - counts ones over a 2^W sample window and emits the signed bipolar result
module ustream_bi_to_bin
  import ustream_pkg::*;
#(
  parameter int W = DEF_W
) (
  input logic                 clk,
  input logic                 rst_n,
  ustream_bi_to_bin_if.slave  bus
);

  localparam logic [W:0]   LAST_IDX = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0] HALF     = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

  conv_state_t  state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic         sat_q, sat_d;

  logic         clr;
  logic         take;
  logic         last;
  logic [W:0]   samp_cnt;
  logic [W:0]   ones_cnt;
  logic [W:0]   ones_final;
  logic         samp_term;
  logic         ones_term;

  // Terminal flags gate the enables so neither counter can ever wrap.
  assign take       = (state_q == RUN) && bus.iEn && !samp_term;
  assign last       = take && (samp_cnt == LAST_IDX);
  assign ones_final = ones_cnt + {{W{1'b0}}, bus.iBit};

  uWinCnt #(.W(W)) u_samp_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .en_i   (take),
    .cnt_o  (samp_cnt),
    .term_o (samp_term)
  );

  uWinCnt #(.W(W)) u_ones_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .en_i   (take && bus.iBit && !ones_term),
    .cnt_o  (ones_cnt),
    .term_o (ones_term)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sat_d   = sat_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        // The final bit is folded in here so the result is ready on DONE entry.
        if (last) begin
          state_d = DONE;
          if (ones_final[W]) begin
            data_d = MAX_POS;
            sat_d  = 1'b1;
          end else begin
            data_d = ones_final[W-1:0] - HALF;
            sat_d  = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.iReady) begin
          if (bus.iStart) begin
            state_d = RUN;
            clr     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.oBusy  = (state_q == RUN);
  assign bus.oValid = (state_q == DONE);
  assign bus.oData  = data_q;
  assign bus.oSat   = sat_q;

endmodule
